mem_stream_rr_arb: RTL and testbench

MEM_STREAM_RR_ARB -- requirements
Module: mem_stream_rr_arb

---
 rtl/mem_stream_pkg.sv | 22 ++
 rtl/fifo_v3.sv | 83 ++++++++
 rtl/mem_stream_rr_arb.sv | 178 +++++++++++++++++
 tb/tb_mem_stream_rr_arb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stream_pkg.sv
// Shared types and helpers for the memory-stream round-robin arbiter.
// The request bundle is sized for the widest supported configuration;
// instances zero-extend their narrower fields into it.
package mem_stream_pkg;

    localparam int unsigned MaxAddrWidth = 64;
    localparam int unsigned MaxDataWidth = 256;
    localparam int unsigned MaxStrbWidth = MaxDataWidth / 8;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] addr;
        logic [MaxDataWidth-1:0] wdata;
        logic [MaxStrbWidth-1:0] strb;
        logic                    we;
    } mem_req_t;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_v3.sv
// Small synchronous FIFO with occupancy count. A push into a full FIFO is
// accepted only when a pop happens on the same cycle. With FALL_THROUGH=0
// a pop never returns data pushed on the same cycle.
module fifo_v3 #(
    parameter bit          FALL_THROUGH = 1'b0,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 8,
    localparam int unsigned AddrW       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CntW        = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [CntW-1:0]       usage_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AddrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AddrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (cnt_q == CntW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;

    // Effective push/pop and read data, including the optional bypass.
    always_comb begin
        data_o  = mem_q[rd_ptr_q];
        do_pop  = pop_i && !empty_o;
        do_push = push_i && (!full_o || do_pop);
        if (FALL_THROUGH && empty_o) begin
            data_o = data_i;
            if (push_i && pop_i) begin
                do_push = 1'b0;
            end
        end
    end

    // Pointer and count next state; pointers wrap at DEPTH, not at 2**AddrW.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == AddrW'(DEPTH - 1)) ? '0 : rd_ptr_q + AddrW'(1);
        end
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == AddrW'(DEPTH - 1)) ? '0 : wr_ptr_q + AddrW'(1);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CntW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mem_stream_rr_arb.sv
// Round-robin arbiter multiplexing several memory-stream requesters onto one
// downstream memory port. Requests pass through combinationally; a route FIFO
// remembers which requester owns each in-order response.
module mem_stream_rr_arb
    import mem_stream_pkg::*;
#(
    parameter int unsigned NumReq         = 2,
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_i,
    output logic [NumReq-1:0]                  gnt_o,
    input  logic [NumReq-1:0][AddrWidth-1:0]   addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0]   wdata_i,
    input  logic [NumReq-1:0][DataWidth/8-1:0] strb_i,
    input  logic [NumReq-1:0]                  we_i,
    output logic [NumReq-1:0]                  rvalid_o,
    output logic [DataWidth-1:0]               rdata_o,
    output logic                               mem_req_o,
    input  logic                               mem_gnt_i,
    output logic [AddrWidth-1:0]               mem_addr_o,
    output logic [DataWidth-1:0]               mem_wdata_o,
    output logic [DataWidth/8-1:0]             mem_strb_o,
    output logic                               mem_we_o,
    input  logic                               mem_rvalid_i,
    input  logic [DataWidth-1:0]               mem_rdata_i,
    output logic                               busy_o
);

    localparam int unsigned IdxW  = idx_width(NumReq);
    localparam int unsigned StrbW = DataWidth / 8;
    localparam int unsigned CntW  = $clog2(MaxOutstanding + 1);

    typedef logic [IdxW-1:0] idx_t;

    if (NumReq < 2 || NumReq > 16) begin : g_bad_numreq
        $error("mem_stream_rr_arb: NumReq must be within 2..16");
    end
    if (DataWidth % 8 != 0 || DataWidth > MaxDataWidth) begin : g_bad_dw
        $error("mem_stream_rr_arb: DataWidth must be a byte multiple within the package maximum");
    end
    if (AddrWidth > MaxAddrWidth) begin : g_bad_aw
        $error("mem_stream_rr_arb: AddrWidth exceeds the package maximum");
    end
    if (MaxOutstanding < 1) begin : g_bad_mo
        $error("mem_stream_rr_arb: MaxOutstanding must be at least 1");
    end

    idx_t            ptr_q, ptr_d;
    logic            lock_q, lock_d;
    idx_t            lock_idx_q, lock_idx_d;
    idx_t            rr_idx;
    logic            rr_found;
    int unsigned     cand;
    idx_t            sel_idx;
    logic            sel_valid;
    mem_req_t        sel_req;
    logic            unused_sel_req;
    logic            can_issue;
    logic            hs;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [CntW-1:0] fifo_usage;
    idx_t            fifo_head;

    // Round-robin search: first asserted request at or after the pointer, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= NumReq) begin
                cand = cand - NumReq;
            end
            if (!rr_found && req_i[idx_t'(cand)]) begin
                rr_found = 1'b1;
                rr_idx   = idx_t'(cand);
            end
        end
    end

    // A stalled request keeps its slot; otherwise the round-robin winner is used.
    always_comb begin
        sel_idx   = lock_q ? lock_idx_q : rr_idx;
        sel_valid = lock_q ? req_i[lock_idx_q] : rr_found;
    end

    // Gather the selected requester's fields into the shared request bundle.
    always_comb begin
        sel_req       = '0;
        sel_req.addr  = MaxAddrWidth'(addr_i[sel_idx]);
        sel_req.wdata = MaxDataWidth'(wdata_i[sel_idx]);
        sel_req.strb  = MaxStrbWidth'(strb_i[sel_idx]);
        sel_req.we    = we_i[sel_idx];
    end

    assign mem_addr_o  = sel_req.addr[AddrWidth-1:0];
    assign mem_wdata_o = sel_req.wdata[DataWidth-1:0];
    assign mem_strb_o  = sel_req.strb[StrbW-1:0];
    assign mem_we_o    = sel_req.we;
    assign unused_sel_req = ^sel_req;

    // A full route FIFO can still take a push when a response frees a slot this cycle.
    assign can_issue = !fifo_full || mem_rvalid_i;
    assign mem_req_o = !rst_i && sel_valid && can_issue;
    assign hs        = mem_req_o && mem_gnt_i;
    assign pop       = !rst_i && mem_rvalid_i && !fifo_empty;
    assign rdata_o   = mem_rdata_i;
    assign busy_o    = !rst_i && ((|req_i) || (fifo_usage != '0));

    // One-hot grant and response steering.
    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (hs) begin
            gnt_o[sel_idx] = 1'b1;
        end
        if (pop) begin
            rvalid_o[fifo_head] = 1'b1;
        end
    end

    // Pointer advances past the winner on a handshake; lock tracks a stalled request.
    always_comb begin
        ptr_d = ptr_q;
        if (hs) begin
            ptr_d = (sel_idx == idx_t'(NumReq - 1)) ? '0 : sel_idx + idx_t'(1);
        end
        lock_d     = mem_req_o && !mem_gnt_i;
        lock_idx_d = lock_d ? sel_idx : lock_idx_q;
    end

    // Arbiter state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    fifo_v3 #(
        .FALL_THROUGH (1'b0),
        .DATA_WIDTH   (IdxW),
        .DEPTH        (MaxOutstanding)
    ) u_route_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_usage),
        .data_i  (sel_idx),
        .push_i  (hs),
        .data_o  (fifo_head),
        .pop_i   (pop)
    );

    // Protocol checks: a stalled requester must hold its request, and
    // responses must have a matching route.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!lock_q || req_i[lock_idx_q])
                else $warning("mem_stream_rr_arb: stalled requester %0d withdrew its request", lock_idx_q);
            assert (!mem_rvalid_i || !fifo_empty)
                else $warning("mem_stream_rr_arb: response with no outstanding route dropped");
        end
    end

endmodule

// File: tb/tb_mem_stream_rr_arb.sv
// Bench for mem_stream_rr_arb: directed scenarios followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_mem_stream_rr_arb;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MO = 4;

    logic                   clk;
    logic                   rst;
    logic [N-1:0]           req;
    logic [N-1:0]           gnt;
    logic [N-1:0][AW-1:0]   addr_in;
    logic [N-1:0][DW-1:0]   wdata_in;
    logic [N-1:0][DW/8-1:0] strb_in;
    logic [N-1:0]           we_in;
    logic [N-1:0]           rvalid;
    logic [DW-1:0]          rdata;
    logic                   mem_req;
    logic                   mem_gnt;
    logic [AW-1:0]          mem_addr;
    logic [DW-1:0]          mem_wdata;
    logic [DW/8-1:0]        mem_strb;
    logic                   mem_we;
    logic                   mem_rvalid;
    logic [DW-1:0]          mem_rdata;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    // reference model state
    int ptr_m  = 0;
    int held_m = -1;
    int q_m[$];

    // observations captured at the sample point of the last apply()
    logic [N-1:0]  obs_gnt, obs_rvalid;
    logic          obs_req, obs_busy, obs_we;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_rdata;
    bit            last_hs;
    int            last_sel;

    logic [DW-1:0] mem_model [0:63];
    bit            pend [N];

    mem_stream_rr_arb #(
        .NumReq(N), .AddrWidth(AW), .DataWidth(DW), .MaxOutstanding(MO)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt),
        .addr_i(addr_in), .wdata_i(wdata_in), .strb_i(strb_in), .we_i(we_in),
        .rvalid_o(rvalid), .rdata_o(rdata),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_strb_o(mem_strb), .mem_we_o(mem_we),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check one cycle against the model, then advance the model across the clock edge.
    task automatic apply(input string tag);
        int           sel;
        bit           ereq, ehs;
        logic [N-1:0] egnt, ervalid;
        bit           ebusy;
        #1;
        sel = -1;
        if (held_m >= 0) sel = held_m;
        else begin
            for (int i = 0; i < N; i++) begin
                int c = (ptr_m + i) % N;
                if (sel < 0 && req[c]) sel = c;
            end
        end
        ereq    = !rst && sel >= 0 && req[sel] && (q_m.size() < MO || mem_rvalid);
        ehs     = ereq && mem_gnt;
        egnt    = '0;
        if (ehs) egnt[sel] = 1'b1;
        ervalid = '0;
        if (!rst && mem_rvalid && q_m.size() > 0) ervalid[q_m[0]] = 1'b1;
        ebusy   = !rst && ((|req) || q_m.size() > 0);

        obs_gnt = gnt; obs_rvalid = rvalid; obs_req = mem_req; obs_busy = busy;
        obs_addr = mem_addr; obs_wdata = mem_wdata; obs_we = mem_we; obs_rdata = rdata;

        chk({tag, "_mem_req"}, 64'(mem_req), 64'(ereq));
        chk({tag, "_gnt"},     64'(gnt),     64'(egnt));
        chk({tag, "_rvalid"},  64'(rvalid),  64'(ervalid));
        chk({tag, "_busy"},    64'(busy),    64'(ebusy));
        if (ereq) begin
            chk({tag, "_addr"},  64'(mem_addr),  64'(addr_in[sel]));
            chk({tag, "_wdata"}, 64'(mem_wdata), 64'(wdata_in[sel]));
            chk({tag, "_strb"},  64'(mem_strb),  64'(strb_in[sel]));
            chk({tag, "_we"},    64'(mem_we),    64'(we_in[sel]));
        end
        if (ervalid != '0) chk({tag, "_rdata"}, 64'(rdata), 64'(mem_rdata));

        @(posedge clk);
        if (rst) begin
            ptr_m = 0; held_m = -1; q_m.delete();
        end else begin
            if (ervalid != '0) void'(q_m.pop_front());
            if (ehs) begin
                q_m.push_back(sel);
                ptr_m = (sel + 1) % N;
            end
            held_m = (ereq && !mem_gnt) ? sel : -1;
        end
        last_hs  = ehs;
        last_sel = sel;
        #1;
    endtask

    initial begin
        rst = 1'b1; req = '1; addr_in = '0; wdata_in = '0; strb_in = '0; we_in = '0;
        mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
        for (int i = 0; i < 64; i++) mem_model[i] = 32'h0;
        mem_model[4] = 32'hCAFE_0010;
        @(posedge clk); #1;

        // reset: outputs quiet even with requests and grant present
        apply("rst0");
        apply("rst1");
        chk("rst_mem_req", 64'(obs_req), 64'h0);
        chk("rst_busy", 64'(obs_busy), 64'h0);
        rst = 1'b0; req = '0; mem_gnt = 1'b0;

        // alternating grants with responses one cycle later
        addr_in[0] = 32'h100; addr_in[1] = 32'h104;
        req = 3'b011; mem_gnt = 1'b1;
        for (int i = 0; i < 5; i++) begin
            mem_rvalid = (i > 0);
            apply("alt");
            chk("alt_gnt", 64'(obs_gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
            if (i > 0) chk("alt_rvalid", 64'(obs_rvalid), ((i - 1) % 2 == 0) ? 64'h1 : 64'h2);
        end
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        apply("alt_drain");
        chk("alt_drain_rvalid", 64'(obs_rvalid), 64'h1);
        mem_rvalid = 1'b0;

        // stall lock: pointer now favours requester 1, but 0 is stalled first
        addr_in[0] = 32'h200; addr_in[1] = 32'h300;
        req = 3'b001; mem_gnt = 1'b0;
        apply("lock0");
        chk("lock0_addr", 64'(obs_addr), 64'h200);
        req = 3'b011;
        apply("lock1");
        chk("lock1_addr", 64'(obs_addr), 64'h200);
        apply("lock2");
        chk("lock2_addr", 64'(obs_addr), 64'h200);
        mem_gnt = 1'b1;
        apply("lock3");
        chk("lock3_gnt", 64'(obs_gnt), 64'h1);
        req = 3'b010;
        apply("lock4");
        chk("lock4_gnt", 64'(obs_gnt), 64'h2);
        chk("lock4_addr", 64'(obs_addr), 64'h300);
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        apply("lock_d0");
        chk("lock_d0_rvalid", 64'(obs_rvalid), 64'h1);
        apply("lock_d1");
        chk("lock_d1_rvalid", 64'(obs_rvalid), 64'h2);
        mem_rvalid = 1'b0;

        // full route FIFO blocks issue until a response frees a slot
        req = 3'b001; mem_gnt = 1'b1;
        for (int i = 0; i < MO; i++) begin
            apply("fill");
            chk("fill_gnt", 64'(obs_gnt), 64'h1);
        end
        apply("full");
        chk("full_mem_req", 64'(obs_req), 64'h0);
        chk("full_gnt", 64'(obs_gnt), 64'h0);
        chk("full_busy", 64'(obs_busy), 64'h1);
        mem_rvalid = 1'b1;
        apply("full_pp");
        chk("full_pp_mem_req", 64'(obs_req), 64'h1);
        chk("full_pp_gnt", 64'(obs_gnt), 64'h1);
        chk("full_pp_rvalid", 64'(obs_rvalid), 64'h1);
        req = '0; mem_gnt = 1'b0;
        for (int i = 0; i < MO; i++) begin
            apply("full_drain");
            chk("full_drain_rvalid", 64'(obs_rvalid), 64'h1);
        end
        mem_rvalid = 1'b0;
        apply("idle");
        chk("idle_busy", 64'(obs_busy), 64'h0);

        // read from requester 0, write from requester 1, responses 3 cycles later
        addr_in[0] = 32'h10; we_in[0] = 1'b0;
        addr_in[1] = 32'h20; we_in[1] = 1'b1; wdata_in[1] = 32'h5555_AAAA; strb_in[1] = 4'hF;
        req = 3'b001; mem_gnt = 1'b1;
        apply("ooo_rd");
        chk("ooo_rd_gnt", 64'(obs_gnt), 64'h1);
        chk("ooo_rd_addr", 64'(obs_addr), 64'h10);
        req = 3'b010;
        apply("ooo_wr");
        chk("ooo_wr_gnt", 64'(obs_gnt), 64'h2);
        chk("ooo_wr_we", 64'(obs_we), 64'h1);
        chk("ooo_wr_wdata", 64'(obs_wdata), 64'h5555_AAAA);
        req = '0; mem_gnt = 1'b0;
        apply("ooo_wait");
        mem_rvalid = 1'b1; mem_rdata = mem_model[32'h10 >> 2];
        apply("ooo_rsp0");
        chk("ooo_rsp0_rvalid", 64'(obs_rvalid), 64'h1);
        chk("ooo_rsp0_rdata", 64'(obs_rdata), 64'hCAFE_0010);
        mem_model[32'h20 >> 2] = 32'h5555_AAAA; mem_rdata = '0;
        apply("ooo_rsp1");
        chk("ooo_rsp1_rvalid", 64'(obs_rvalid), 64'h2);
        mem_rvalid = 1'b0;

        // reset with two outstanding, then a late response is dropped
        req = 3'b011; mem_gnt = 1'b1;
        apply("rr0");
        apply("rr1");
        req = '0; mem_gnt = 1'b0; rst = 1'b1;
        apply("rr_rst");
        rst = 1'b0; mem_rvalid = 1'b1;
        apply("rr_late");
        chk("rr_late_rvalid", 64'(obs_rvalid), 64'h0);
        chk("rr_late_busy", 64'(obs_busy), 64'h0);
        mem_rvalid = 1'b0;

        // wrap-around from pointer 2
        req = 3'b010; mem_gnt = 1'b1;
        apply("wrap_set");
        chk("wrap_set_gnt", 64'(obs_gnt), 64'h2);
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        apply("wrap_drain");
        mem_rvalid = 1'b0; req = 3'b011; mem_gnt = 1'b1;
        apply("wrap0");
        chk("wrap0_gnt", 64'(obs_gnt), 64'h1);
        apply("wrap1");
        chk("wrap1_gnt", 64'(obs_gnt), 64'h2);
        req = '0; mem_gnt = 1'b0; mem_rvalid = 1'b1;
        apply("wrap_d0");
        apply("wrap_d1");
        mem_rvalid = 1'b0;

        // randomized traffic with protocol-compliant requesters
        for (int k = 0; k < N; k++) pend[k] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = (cyc == 200);
            for (int k = 0; k < N; k++) begin
                if (rst) pend[k] = 1'b0;
                else if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k]     = 1'b1;
                    addr_in[k]  = $urandom & 32'hFFFF_FFFC;
                    wdata_in[k] = $urandom;
                    strb_in[k]  = 4'($urandom_range(0, 15));
                    we_in[k]    = 1'($urandom_range(0, 1));
                end
                req[k] = pend[k];
            end
            mem_gnt    = ($urandom_range(0, 3) != 0);
            mem_rvalid = (q_m.size() > 0) && ($urandom_range(0, 2) == 0);
            mem_rdata  = $urandom;
            apply("rnd");
            if (last_hs) pend[last_sel] = 1'b0;
        end
        rst = 1'b0; req = '0; mem_gnt = 1'b0;
        for (int i = 0; i < MO + 2; i++) begin
            mem_rvalid = (q_m.size() > 0);
            mem_rdata  = $urandom;
            apply("rnd_drain");
        end
        mem_rvalid = 1'b0;
        apply("end");
        chk("end_busy", 64'(obs_busy), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
